// File: rtl/tlu_event_packer.sv
// Buffers TLU trigger events and serializes each into 32-bit words; 3 words/event with TLU_EVENT_PACKER_TIMESTAMP_EN, else 1.
// Latency: the event sampled at one edge shows as W0 two edges after it is driven; after that, one word per FIFO_READ.
// Backpressure: events arriving while the buffer is full are dropped and counted; the output holds its word until FIFO_READ.
module tlu_event_packer #(
    parameter int DEPTH_BITS = 3
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        EVT_WE,
    input  logic [31:0] EVT_TRIG_ID,
    input  logic [63:0] EVT_TIME_STAMP,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT,
    output logic [31:0] EVT_CNT
);
    localparam int DEPTH = 2 ** DEPTH_BITS;
`ifdef TLU_EVENT_PACKER_TIMESTAMP_EN
    localparam int ENTRY_W = 90;
`else
    localparam int ENTRY_W = 30;
`endif

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t                state, state_nxt;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    hold;
    logic [ENTRY_W-1:0]    entry_dat;
    logic [DEPTH_BITS:0]   wr_ptr, rd_ptr, occ;
    logic [DEPTH_BITS-1:0] rd_idx, rd_idx_p1;
    logic                  buf_full, buf_vld, buf_more;
    logic                  evt_vld, wr_en;
    logic                  last_word, load, load_next, ent_free;
    logic                  unused_bits;

`ifdef TLU_EVENT_PACKER_TIMESTAMP_EN
    assign entry_dat   = {EVT_TIME_STAMP[59:0], EVT_TRIG_ID[29:0]};
    assign unused_bits = ^{EVT_TRIG_ID[31:30], EVT_TIME_STAMP[63:60]};
    assign last_word   = (state == W2);
`else
    assign entry_dat   = EVT_TRIG_ID[29:0];
    assign unused_bits = ^{EVT_TRIG_ID[31:30], EVT_TIME_STAMP};
    assign last_word   = (state == W0);
`endif

    // The event being serialized keeps its slot until its last word is read,
    // so occupancy counts it and the next event is peeked at rd_ptr+1.
    assign occ       = wr_ptr - rd_ptr;
    assign buf_full  = occ[DEPTH_BITS];
    assign buf_vld   = (occ != '0);
    assign buf_more  = (occ > (DEPTH_BITS + 1)'(1));
    assign rd_idx    = rd_ptr[DEPTH_BITS-1:0];
    assign rd_idx_p1 = rd_idx + DEPTH_BITS'(1);
    assign evt_vld   = EVT_WE && ENABLE;
    assign wr_en     = evt_vld && !buf_full;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_next = 1'b0;
        ent_free  = 1'b0;
        case (state)
            IDLE: begin
                if (buf_vld) begin
                    load      = 1'b1;
                    state_nxt = W0;
                end
            end
            default: begin
                if (FIFO_READ) begin
                    if (last_word) begin
                        ent_free = 1'b1;
                        if (buf_more) begin
                            load      = 1'b1;
                            load_next = 1'b1;
                            state_nxt = W0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (state == W0) begin
                        state_nxt = W1;
                    end else begin
                        state_nxt = W2;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            hold     <= '0;
            EVT_CNT  <= '0;
            LOST_CNT <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + (DEPTH_BITS + 1)'(1);
            if (ent_free)
                rd_ptr <= rd_ptr + (DEPTH_BITS + 1)'(1);
            if (load)
                hold <= load_next ? mem[rd_idx_p1] : mem[rd_idx];
            if (evt_vld) begin
                if (!buf_full)
                    EVT_CNT <= EVT_CNT + 32'd1;
                else if (LOST_CNT != 8'hFF)
                    LOST_CNT <= LOST_CNT + 8'd1;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (wr_en)
            mem[wr_ptr[DEPTH_BITS-1:0]] <= entry_dat;
    end

    assign FIFO_EMPTY = (state == IDLE);

    always_comb begin
        FIFO_DATA = '0;
        case (state)
            W0:      FIFO_DATA = {2'b11, hold[29:0]};
`ifdef TLU_EVENT_PACKER_TIMESTAMP_EN
            W1:      FIFO_DATA = {2'b10, hold[59:30]};
            W2:      FIFO_DATA = {2'b01, hold[89:60]};
`endif
            default: FIFO_DATA = '0;
        endcase
    end
endmodule

// File: tb/tb_tlu_event_packer.sv
// Bench for tlu_event_packer: directed scenarios plus random traffic against a queue-level event model.
module tb_tlu_event_packer;
    localparam int DEPTH = 8;
`ifdef TLU_EVENT_PACKER_TIMESTAMP_EN
    localparam int WPE = 3;
`else
    localparam int WPE = 1;
`endif

    logic        BUS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        EVT_WE = 1'b0;
    logic [31:0] EVT_TRIG_ID = '0;
    logic [63:0] EVT_TIME_STAMP = '0;
    logic        FIFO_READ = 1'b0;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_CNT;
    logic [31:0] EVT_CNT;

    tlu_event_packer #(.DEPTH_BITS(3)) dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .ENABLE(ENABLE), .EVT_WE(EVT_WE),
        .EVT_TRIG_ID(EVT_TRIG_ID), .EVT_TIME_STAMP(EVT_TIME_STAMP),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .LOST_CNT(LOST_CNT), .EVT_CNT(EVT_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    typedef struct packed {
        logic [31:0] id;
        logic [63:0] ts;
    } evt_t;

    int          total = 0;
    int          bad = 0;
    evt_t        q[$];
    bit          svc = 1'b0;
    int          widx = 0;
    logic [31:0] m_evt = '0;
    int          m_lost = 0;
    logic [63:0] ts_arr [10];
    logic [31:0] evt_before;

    function automatic logic [31:0] word_of(input evt_t e, input int k);
        case (k)
            0:       return {2'b11, e.id[29:0]};
            1:       return {2'b10, e.ts[29:0]};
            default: return {2'b01, e.ts[59:30]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic step(input bit rst, input bit en, input bit we,
                        input logic [31:0] id, input logic [63:0] ts, input bit rd);
        int   sz0;
        evt_t e;
        RST = rst; ENABLE = en; EVT_WE = we;
        EVT_TRIG_ID = id; EVT_TIME_STAMP = ts; FIFO_READ = rd;
        @(posedge BUS_CLK);
        if (rst) begin
            q.delete(); svc = 1'b0; widx = 0; m_evt = '0; m_lost = 0;
        end else begin
            sz0 = q.size();
            if (!svc) begin
                if (sz0 > 0) begin svc = 1'b1; widx = 0; end
            end else if (rd) begin
                if (widx == WPE - 1) begin
                    q.delete(0);
                    if (sz0 > 1) widx = 0;
                    else svc = 1'b0;
                end else begin
                    widx++;
                end
            end
            if (we && en) begin
                if (sz0 < DEPTH) begin
                    e.id = id; e.ts = ts;
                    q.push_back(e);
                    m_evt = m_evt + 32'd1;
                end else if (m_lost < 255) begin
                    m_lost++;
                end
            end
        end
        #1;
        check("model_empty", {31'd0, FIFO_EMPTY}, svc ? 32'd0 : 32'd1);
        check("model_data", FIFO_DATA, svc ? word_of(q[0], widx) : 32'd0);
        check("model_evt_cnt", EVT_CNT, m_evt);
        check("model_lost_cnt", {24'd0, LOST_CNT}, m_lost);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("rst_data", FIFO_DATA, 32'd0);
        check("rst_lost", {24'd0, LOST_CNT}, 32'd0);
        check("rst_evt", EVT_CNT, 32'd0);

        // single event and two-edge latency
        step(0, 1, 1, 32'd5, 64'h0000_0001_0000_0003, 0);
        check("lat_first_edge_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        step(0, 1, 0, 0, 0, 0);
        check("lat_second_edge_empty", {31'd0, FIFO_EMPTY}, 32'd0);
        check("single_w0", FIFO_DATA, 32'hC000_0005);
        idle(2);
        check("single_w0_stable", FIFO_DATA, 32'hC000_0005);
`ifdef TLU_EVENT_PACKER_TIMESTAMP_EN
        step(0, 1, 0, 0, 0, 1);
        check("single_w1", FIFO_DATA, 32'h8000_0003);
        step(0, 1, 0, 0, 0, 1);
        check("single_w2", FIFO_DATA, 32'h4000_0004);
`endif
        step(0, 1, 0, 0, 0, 1);
        check("single_done_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        step(0, 1, 0, 0, 0, 1);
        check("read_while_empty", {31'd0, FIFO_EMPTY}, 32'd1);

        // strobes while disabled are ignored
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'd99, 64'd1, 0);
        check("disabled_evt", EVT_CNT, 32'd1);
        check("disabled_empty", {31'd0, FIFO_EMPTY}, 32'd1);

        // overflow: 10 strobes without reads
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            ts_arr[i] = {$urandom(), $urandom()};
            step(0, 1, 1, i, ts_arr[i], 0);
        end
        check("ovf_lost", {24'd0, LOST_CNT}, 32'd2);
        check("ovf_evt", EVT_CNT, 32'd8);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < WPE; k++) begin
                evt_t e;
                e.id = i; e.ts = ts_arr[i];
                check("ovf_word", FIFO_DATA, word_of(e, k));
                step(0, 1, 0, 0, 0, 1);
            end
        end
        check("ovf_drained", {31'd0, FIFO_EMPTY}, 32'd1);

        // back-to-back readout, then IDs 7,8,9
        step(0, 1, 1, 32'h0ABC_0001, 64'h0FFF_FFFF_FFFF_FFFF, 0);
        step(0, 1, 1, 32'h3FFF_FFFF, 64'h0123_4567_89AB_CDEF, 0);
        for (int n = 0; n < 2 * WPE; n++) begin
            check("b2b_nonempty", {31'd0, FIFO_EMPTY}, 32'd0);
            step(0, 1, 0, 0, 0, 1);
        end
        check("b2b_done", {31'd0, FIFO_EMPTY}, 32'd1);
        for (int i = 7; i <= 9; i++) step(0, 1, 1, i, {$urandom(), $urandom()}, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 7; i <= 9; i++) begin
            check("id789_w0", FIFO_DATA, 32'hC000_0000 | i);
            for (int k = 0; k < WPE; k++) step(0, 1, 0, 0, 0, 1);
        end
        check("id789_done", {31'd0, FIFO_EMPTY}, 32'd1);

        // saturation of the lost counter
        evt_before = m_evt;
        for (int i = 0; i < 308; i++) step(0, 1, 1, i, {$urandom(), $urandom()}, 0);
        check("sat_lost", {24'd0, LOST_CNT}, 32'd255);
        check("sat_evt", EVT_CNT, evt_before + 32'd8);

        // reset mid-event, colliding with a strobe and a read
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h11, 64'h5, 0);
        step(0, 1, 1, 32'h12, 64'h6, 0);
        step(0, 1, 0, 0, 0, 1);
        step(1, 1, 1, 32'h13, 64'h7, 1);
        check("mid_rst_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("mid_rst_data", FIFO_DATA, 32'd0);
        check("mid_rst_evt", EVT_CNT, 32'd0);
        idle(3);
        check("mid_rst_no_residue", {31'd0, FIFO_EMPTY}, 32'd1);
        step(0, 1, 1, 32'h22, 64'h9, 0);
        step(0, 1, 0, 0, 0, 0);
        check("post_rst_w0", FIFO_DATA, 32'hC000_0022);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < 45),
                 $urandom(), {$urandom(), $urandom()},
                 ($urandom_range(0, 99) < 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlu_event_packer.md
TLU_EVENT_PACKER -- requirements
Module: tlu_event_packer

Interface
REQ-001 Parameter: DEPTH_BITS, default 3, log2 of event buffer depth (8 events).
REQ-002 Clock and reset: the block SHALL use clock BUS_CLK; reset RST SHALL be synchronous and active-high.
REQ-003 BUS_CLK  in  1  sole clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 ENABLE  in  1  accept events when 1.
REQ-006 EVT_WE  in  1  one-cycle event strobe from trigger logic.
REQ-007 EVT_TRIG_ID  in  32  trigger number, sampled on EVT_WE.
REQ-008 EVT_TIME_STAMP  in  64  40 MHz timestamp, sampled on EVT_WE.
REQ-009 FIFO_READ  in  1  pop current output word.
REQ-010 FIFO_EMPTY  out  1  no word available.
REQ-011 FIFO_DATA  out  32  current word, valid while FIFO_EMPTY=0 (first-word-fall-through).
REQ-012 LOST_CNT  out  8  saturating count of dropped events.
REQ-013 EVT_CNT  out  32  count of accepted events.

Function
REQ-014 Event buffer SHALL be a circular FIFO of 2**DEPTH_BITS entries, each holding TRIG_ID[29:0] and TIME_STAMP[59:0].
REQ-015 EVT_WE=1, ENABLE=1, buffer not full: event written; EVT_CNT increments (wraps at 2**32-1 to 0).
REQ-016 EVT_WE=1, ENABLE=1, buffer full: event dropped; LOST_CNT increments, saturating at 255.
REQ-017 Fullness SHALL be evaluated on registered state before the edge; a write while full is dropped even if the serializer pops in the same cycle.
REQ-018 EVT_WE with ENABLE=0: ignored; neither counter changes.
REQ-019 Serializer FSM states: IDLE, W0, W1, W2.
REQ-020 IDLE with buffer non-empty: pop one entry into the output holding register and go to W0.
REQ-021 Word formats: W0={2'b11, TRIG_ID[29:0]}; W1={2'b10, TS[29:0]}; W2={2'b01, TS[59:30]}.
REQ-022 FIFO_EMPTY SHALL be 1 in IDLE and 0 in W0/W1/W2.
REQ-023 FIFO_READ with FIFO_EMPTY=0: advance W0->W1->W2.
REQ-024 From W2, FIFO_READ with buffer non-empty: go to W0 of the next event, with no empty cycle. With buffer empty: go to IDLE.
REQ-025 FIFO_READ while FIFO_EMPTY=1: no effect.
REQ-026 Latency: EVT_WE at edge n into an empty block gives FIFO_EMPTY=0 after edge n+2.
REQ-027 FIFO_DATA SHALL be stable while FIFO_EMPTY=0 and FIFO_READ=0.
REQ-028 Event write and serializer pop in the same cycle SHALL both take effect; occupancy is unchanged.

Reset
REQ-029 RST SHALL set: FSM=IDLE, read and write pointers=0, FIFO_EMPTY=1, FIFO_DATA=0, LOST_CNT=0, EVT_CNT=0.
REQ-030 RST mid-event SHALL discard the partially read event and all buffered events; no residual words appear.
REQ-031 RST has priority over EVT_WE and FIFO_READ in the same cycle.

Configuration
REQ-032 Macro TLU_EVENT_PACKER_TIMESTAMP_EN defined: 3 words per event (W0, W1, W2) and 60 timestamp bits stored per entry.
REQ-033 Macro TLU_EVENT_PACKER_TIMESTAMP_EN undefined:
- only W0 is emitted; from W0, FIFO_READ follows the REQ-024 W2 rules;
- timestamp storage is not synthesized;
- EVT_TIME_STAMP is ignored.

Verification
REQ-034 Single event: TRIG_ID=5, TS=64'h0000_0001_0000_0003 -> words 0xC0000005, 0x80000003, 0x40000004; then FIFO_EMPTY=1.
REQ-035 Overflow: 10 strobes, no reads, DEPTH_BITS=3 -> LOST_CNT=2, EVT_CNT=8; readout yields 24 words for IDs 0..7.
REQ-036 Back-to-back: 2 events buffered, FIFO_READ held 1 -> 6 consecutive words with FIFO_EMPTY never 1 between events.
REQ-037 Saturation: 300 strobes into a full buffer -> LOST_CNT=255.
REQ-038 Reset mid-event: RST after reading W0 -> FIFO_EMPTY=1 next cycle; a new event emits W0 first.
REQ-039 Macro undefined: 3 events with IDs 7, 8, 9 -> words 0xC0000007, 0xC0000008, 0xC0000009 only.
